// File: rtl/perf_pkg.sv
// perf_pkg: types and constants shared by the perf_sys schedulers.
//   state_t     : scheduler FSM states (IDLE/RUN/DELIVER/FLUSH)
//   TYPE_A/B/C  : generator lane-pattern encodings (2'b11 is never used)
//   nonce_t     : 8-bit nonce value
//   next_type() : lane-pattern rotation A -> B -> C -> A
package perf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_DELIVER = 2'd2,
        ST_FLUSH   = 2'd3
    } state_t;

    localparam logic [1:0] TYPE_A = 2'b00;
    localparam logic [1:0] TYPE_B = 2'b01;
    localparam logic [1:0] TYPE_C = 2'b10;

    typedef logic [7:0] nonce_t;

    // Anything outside the legal set falls back to TYPE_A so 2'b11 can
    // never be reached even from a corrupted register.
    function automatic logic [1:0] next_type(input logic [1:0] t);
        case (t)
            TYPE_A:  return TYPE_B;
            TYPE_B:  return TYPE_C;
            default: return TYPE_A;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   req [NREQ]  : request vector
//   ptr [IW]    : highest-priority index this round
//   gnt [NREQ]  : one-hot grant (zero when no request)
//   idx [IW]    : index of the granted requester
//   any         : at least one request present
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);

    // Scan NREQ positions starting at ptr, wrapping; first hit wins.
    always_comb begin
        int p;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        p   = 0;
        for (int k = 0; k < NREQ; k++) begin
            p = int'(ptr) + k;
            if (p >= NREQ) p = p - NREQ;
            if (!any && req[p]) begin
                any    = 1'b1;
                gnt[p] = 1'b1;
                idx    = IW'(p);
            end
        end
    end

endmodule

// File: rtl/nonce_sched.sv
// nonce_sched: round-robin scheduler in front of the four-lane nonce
// generator. Grants one requester per batch, holds generator inputs for
// HOLD cycles, captures the four lanes and returns them with valid/ready.
//   clk, reset            : clock, synchronous active-high reset
//   req / gnt             : per-requester level request / one-cycle grant
//   abort                 : cancel the batch in RUN
//   cfg_stride            : lane stride, sampled at grant
//   gen_source0/1, gen_type, gen_fail : generator controls (registered)
//   gen_nonce0..3         : generator lane results
//   resp_valid/ready/id, resp_nonce0..3 : result handshake
module nonce_sched
    import perf_pkg::*;
#(
    parameter int     NREQ      = 4,
    parameter int     HOLD      = 4,
    parameter nonce_t BASE_INIT = 8'h00
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    output logic [NREQ-1:0]         gnt,
    input  logic                    abort,
    input  logic [7:0]              cfg_stride,
    output logic [7:0]              gen_source0,
    output logic [7:0]              gen_source1,
    output logic [1:0]              gen_type,
    output logic                    gen_fail,
    input  logic [7:0]              gen_nonce0,
    input  logic [7:0]              gen_nonce1,
    input  logic [7:0]              gen_nonce2,
    input  logic [7:0]              gen_nonce3,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [$clog2(NREQ)-1:0] resp_id,
    output logic [7:0]              resp_nonce0,
    output logic [7:0]              resp_nonce1,
    output logic [7:0]              resp_nonce2,
    output logic [7:0]              resp_nonce3
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(HOLD + 1);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    nonce_t            base_q, base_d;
    nonce_t            stride_q, stride_d;
    logic [1:0]        type_q, type_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     id_q, id_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              vld_q, vld_d;
    logic              fail_q, fail_d;
    logic [3:0][7:0]   cap_q, cap_d;

    logic [NREQ-1:0]   arb_gnt;
    logic [IW-1:0]     arb_idx;
    logic              arb_any;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req (req),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        base_d   = base_q;
        stride_d = stride_q;
        type_d   = type_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        gnt_d    = '0;
        vld_d    = vld_q;
        cap_d    = cap_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    gnt_d    = arb_gnt;
                    id_d     = arb_idx;
                    stride_d = cfg_stride;
                    cnt_d    = CW'(HOLD - 1);
                    ptr_d    = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                // abort takes priority over the final-cycle capture
                if (abort) begin
                    state_d = ST_FLUSH;
                end else if (cnt_q == '0) begin
                    cap_d   = {gen_nonce3, gen_nonce2, gen_nonce1, gen_nonce0};
                    vld_d   = 1'b1;
                    state_d = ST_DELIVER;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DELIVER: begin
                if (resp_ready) begin
                    vld_d   = 1'b0;
                    base_d  = base_q + {stride_q[6:0], 1'b0};
                    type_d  = next_type(type_q);
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        // Generator is held cleared whenever no batch is being computed or held.
        fail_d = !(state_d == ST_RUN || state_d == ST_DELIVER);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            base_q   <= BASE_INIT;
            stride_q <= '0;
            type_q   <= TYPE_A;
            ptr_q    <= '0;
            id_q     <= '0;
            gnt_q    <= '0;
            vld_q    <= 1'b0;
            fail_q   <= 1'b1;
            cap_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            base_q   <= base_d;
            stride_q <= stride_d;
            type_q   <= type_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            gnt_q    <= gnt_d;
            vld_q    <= vld_d;
            fail_q   <= fail_d;
            cap_q    <= cap_d;
        end
    end

    assign gnt         = gnt_q;
    assign gen_source0 = base_q;
    assign gen_source1 = stride_q;
    assign gen_type    = type_q;
    assign gen_fail    = fail_q;
    assign resp_valid  = vld_q;
    assign resp_id     = id_q;
    assign resp_nonce0 = cap_q[0];
    assign resp_nonce1 = cap_q[1];
    assign resp_nonce2 = cap_q[2];
    assign resp_nonce3 = cap_q[3];

endmodule

// File: tb/tb_nonce_sched.sv
module tb_nonce_sched;

    localparam int NREQ = 4;
    localparam int HOLD = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // main DUT
    logic [3:0]      req, gnt;
    logic            abort, resp_valid, resp_ready, gen_fail;
    logic [7:0]      cfg_stride, gen_source0, gen_source1;
    logic [1:0]      gen_type, resp_id;
    logic [3:0][7:0] gn, rn;

    // second DUT, used only for base wrap-around from BASE_INIT=FE
    logic [3:0]      req_w, gnt_w;
    logic            abort_w, vld_w, rdy_w, fail_w;
    logic [7:0]      stride_w, src0_w, src1_w;
    logic [1:0]      type_w, id_w;
    logic [3:0][7:0] rn_w;
    logic [7:0]      zero8;

    nonce_sched #(.NREQ(NREQ), .HOLD(HOLD), .BASE_INIT(8'h00)) u_dut (
        .clk(clk), .reset(reset), .req(req), .gnt(gnt), .abort(abort),
        .cfg_stride(cfg_stride), .gen_source0(gen_source0), .gen_source1(gen_source1),
        .gen_type(gen_type), .gen_fail(gen_fail),
        .gen_nonce0(gn[0]), .gen_nonce1(gn[1]), .gen_nonce2(gn[2]), .gen_nonce3(gn[3]),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_nonce0(rn[0]), .resp_nonce1(rn[1]), .resp_nonce2(rn[2]), .resp_nonce3(rn[3])
    );

    nonce_sched #(.NREQ(NREQ), .HOLD(HOLD), .BASE_INIT(8'hFE)) u_wrap (
        .clk(clk), .reset(reset), .req(req_w), .gnt(gnt_w), .abort(abort_w),
        .cfg_stride(stride_w), .gen_source0(src0_w), .gen_source1(src1_w),
        .gen_type(type_w), .gen_fail(fail_w),
        .gen_nonce0(zero8), .gen_nonce1(zero8), .gen_nonce2(zero8), .gen_nonce3(zero8),
        .resp_valid(vld_w), .resp_ready(rdy_w), .resp_id(id_w),
        .resp_nonce0(rn_w[0]), .resp_nonce1(rn_w[1]), .resp_nonce2(rn_w[2]), .resp_nonce3(rn_w[3])
    );

    // Stand-in generator: one-cycle registered lane function, cleared by fail.
    function automatic logic [7:0] gen_lane(input logic [7:0] s0, input logic [7:0] s1,
                                            input logic [1:0] t, input int i);
        logic [7:0] m;
        m = 8'(i * int'(s1));
        case (t)
            2'b00:   return s0 + m;
            2'b01:   return (s0 + m) ^ 8'h5A;
            default: return s0 - m;
        endcase
    endfunction

    always @(posedge clk)
        for (int i = 0; i < 4; i++)
            gn[i] <= gen_fail ? 8'h00 : gen_lane(gen_source0, gen_source1, gen_type, i);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0, n_fail = 0;
    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // reference model: round-robin pointer, base, lane pattern
    int m_ptr, m_base, m_type;
    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < NREQ; k++)
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction
    task automatic model_after(input int id, input logic [7:0] st, input int ab);
        m_ptr = (id + 1) % NREQ;
        if (ab < 0) begin
            m_base = (m_base + 2 * int'(st)) % 256;
            m_type = (m_type + 1) % 3;
        end
    endtask

    // One batch: wait for grant, follow RUN, optional abort at RUN cycle ab,
    // optional rdly cycles of backpressure, then the handshake.
    task automatic do_batch(input logic [3:0] rq, input logic [7:0] st, input int rdly,
                            input int ab, input int e_id, input int e_base,
                            input int e_type, output int gcyc);
        bit got;
        got = 0;
        gcyc = -1;
        req = rq; cfg_stride = st; resp_ready = (rdly == 0); abort = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(posedge clk); @(negedge clk);
            if (gnt != 4'b0) got = 1;
        end
        chk("grant_seen", int'(got), 1);
        if (!got) begin req = '0; return; end
        gcyc = cyc;
        chk("gnt", int'(gnt), 1 << e_id);
        chk("src0", int'(gen_source0), e_base);
        chk("src1", int'(gen_source1), int'(st));
        chk("type", int'(gen_type), e_type);
        chk("fail_run", int'(gen_fail), 0);
        for (int c = 1; c <= HOLD; c++) begin
            if (ab == c - 1) begin abort = 1'b1; req = '0; end
            @(posedge clk); @(negedge clk);
            if (ab == c - 1) begin
                abort = 1'b0;
                chk("flush_fail", int'(gen_fail), 1);
                chk("flush_vld", int'(resp_valid), 0);
                @(posedge clk); @(negedge clk);
                chk("idle_vld", int'(resp_valid), 0);
                chk("idle_base", int'(gen_source0), e_base);
                chk("idle_type", int'(gen_type), e_type);
                return;
            end
            chk("run_gnt", int'(gnt), 0);
            chk("run_src0", int'(gen_source0), e_base);
            chk("vld_timing", int'(resp_valid), int'(c == HOLD));
        end
        chk("resp_id", int'(resp_id), e_id);
        for (int i = 0; i < 4; i++)
            chk($sformatf("lane%0d", i), int'(rn[i]), int'(gen_lane(8'(e_base), st, 2'(e_type), i)));
        if (rdly > 0) begin
            for (int k = 0; k < rdly; k++) begin
                @(posedge clk); @(negedge clk);
                chk("bp_vld", int'(resp_valid), 1);
                chk("bp_id", int'(resp_id), e_id);
                chk("bp_lane0", int'(rn[0]), int'(gen_lane(8'(e_base), st, 2'(e_type), 0)));
                chk("bp_gnt", int'(gnt), 0);
            end
            resp_ready = 1'b1;
        end
        @(posedge clk); @(negedge clk);
        chk("handshake_vld", int'(resp_valid), 0);
    endtask

    typedef struct {
        logic [3:0] rq;
        logic [7:0] st;
        int         rdly;
        int         ab;
        bit         sp;     // check spacing to previous grant
        int         e_id;
        int         e_base;
        int         e_type;
    } vec_t;
    vec_t tbl [11];

    initial begin
        int g, prev_g, wk;
        int wb [4];
        int wt [4];
        tbl[0]  = '{4'b0010, 8'h03,  0, -1, 0, 1, 8'h00, 0};
        tbl[1]  = '{4'b1111, 8'h01,  0, -1, 0, 2, 8'h06, 1};
        tbl[2]  = '{4'b1111, 8'h01,  0, -1, 1, 3, 8'h08, 2};
        tbl[3]  = '{4'b1111, 8'h01,  0, -1, 1, 0, 8'h0A, 0};
        tbl[4]  = '{4'b1111, 8'h01,  0, -1, 1, 1, 8'h0C, 1};
        tbl[5]  = '{4'b1111, 8'h01,  0, -1, 1, 2, 8'h0E, 2};
        tbl[6]  = '{4'b1111, 8'h05, 10, -1, 1, 3, 8'h10, 0};
        tbl[7]  = '{4'b0001, 8'h07,  0,  2, 0, 0, 8'h1A, 1};
        tbl[8]  = '{4'b1001, 8'h02,  0, -1, 0, 3, 8'h1A, 1};
        tbl[9]  = '{4'b0100, 8'h80,  0, -1, 0, 2, 8'h1E, 2};
        tbl[10] = '{4'b1000, 8'h09,  0,  3, 0, 3, 8'h1E, 0};
        wb = '{8'hFE, 8'h02, 8'h06, 8'h0A};
        wt = '{0, 1, 2, 0};

        zero8 = 8'h00;
        req = '0; abort = 0; cfg_stride = 0; resp_ready = 0;
        req_w = '0; abort_w = 0; stride_w = 0; rdy_w = 0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_vld", int'(resp_valid), 0);
        chk("rst_id", int'(resp_id), 0);
        chk("rst_lanes", int'(rn), 0);
        chk("rst_src0", int'(gen_source0), 0);
        chk("rst_src1", int'(gen_source1), 0);
        chk("rst_type", int'(gen_type), 0);
        chk("rst_fail", int'(gen_fail), 1);
        chk("rst_src0_w", int'(src0_w), 8'hFE);
        reset = 1'b0;

        // base wrap from FE with stride 2, pattern rotation including return to A
        req_w = 4'b0001; stride_w = 8'h02; rdy_w = 1'b1;
        wk = 0;
        for (int n = 0; n < 60 && wk < 4; n++) begin
            @(posedge clk); @(negedge clk);
            if (gnt_w != 4'b0) begin
                chk($sformatf("wrap_base%0d", wk), int'(src0_w), wb[wk]);
                chk($sformatf("wrap_type%0d", wk), int'(type_w), wt[wk]);
                wk++;
            end
        end
        chk("wrap_count", wk, 4);
        req_w = '0;

        // directed table
        m_ptr = 0; m_base = 0; m_type = 0;
        prev_g = -1;
        for (int i = 0; i < 11; i++) begin
            do_batch(tbl[i].rq, tbl[i].st, tbl[i].rdly, tbl[i].ab,
                     tbl[i].e_id, tbl[i].e_base, tbl[i].e_type, g);
            if (tbl[i].sp) chk($sformatf("spacing%0d", i), g - prev_g, HOLD + 2);
            prev_g = g;
            model_after(tbl[i].e_id, tbl[i].st, tbl[i].ab);
        end
        req = '0;
        @(posedge clk); @(negedge clk);

        // reset while a response is pending
        req = 4'b0100; cfg_stride = 8'h04; resp_ready = 1'b0;
        wk = 0;
        for (int n = 0; n < 20 && wk == 0; n++) begin
            @(posedge clk); @(negedge clk);
            if (gnt != 4'b0) wk = 1;
        end
        req = '0;
        repeat (HOLD) begin @(posedge clk); @(negedge clk); end
        chk("pre_rst_vld", int'(resp_valid), 1);
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("mid_rst_vld", int'(resp_valid), 0);
        chk("mid_rst_id", int'(resp_id), 0);
        chk("mid_rst_lanes", int'(rn), 0);
        chk("mid_rst_fail", int'(gen_fail), 1);
        chk("mid_rst_src0", int'(gen_source0), 0);
        chk("mid_rst_src1", int'(gen_source1), 0);
        chk("mid_rst_type", int'(gen_type), 0);
        reset = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("post_rst_vld", int'(resp_valid), 0);
        m_ptr = 0; m_base = 0; m_type = 0;

        // randomized batches against the model
        for (int i = 0; i < 40; i++) begin
            logic [3:0] rq;
            logic [7:0] st;
            int rdly, ab, id;
            rq   = 4'($urandom_range(1, 15));
            st   = 8'($urandom);
            rdly = $urandom_range(0, 3);
            ab   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, HOLD - 1) : -1;
            id   = pick(rq, m_ptr);
            do_batch(rq, st, rdly, ab, id, m_base, m_type, g);
            model_after(id, st, ab);
        end
        req = '0;
        @(posedge clk); @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
